ram_hs: RTL and testbench

//  Parametrised single-port data RAM for the CPU data bus; successor of the fixed 1-cycle ram.

---
 rtl/ram_hs_if.sv | 38 +++
 rtl/ram_hs.sv | 232 +++++++++++++++++++++++
 tb/tb_ram_hs.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_hs_if.sv
// ram_hs_if: request/response bus between the CPU load/store path and ram_hs.
//
// Handshake rules, identical on both channels: a transfer happens on a rising
// clock edge where valid and ready are both high. The producer holds valid and
// its payload stable until that edge; valid never depends on ready, while ready
// may depend on valid. Requests carry addr/we/wdata; responses carry
// rdata/err and come back strictly in request order, one per accepted request.
interface ram_hs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 22
);
    localparam int NB = DATA_W / 8;

    // request channel
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [NB-1:0]     req_we;
    logic [DATA_W-1:0] req_wdata;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // CPU side
    modport master (
        output req_valid, req_addr, req_we, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // RAM side
    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_hs.sv
// ram_hs: word-addressed single-port data RAM with valid/ready request and
// response channels, byte-lane write enables, LATENCY-cycle read path,
// in-order responses with backpressure and out-of-range error reporting.
//
// A response becomes visible LATENCY cycles after the cycle its request was
// accepted in: LATENCY-1 register stages followed by an output FIFO of depth
// LATENCY+1 whose head drives rsp_*. A credit counter tracks free slots in
// pipeline + FIFO so the FIFO can never overflow; with rsp_ready held high
// the bank sustains one request per cycle.
//
// Optional feature macro: RAM_PARITY_EN
//   defined   - one even-parity bit per byte lane is stored alongside the data;
//               a lane mismatch on a read sets rsp_err (rdata is unchanged).
//   undefined - no parity storage; rsp_err marks out-of-range addresses only.
module ram_hs #(
    parameter int DATA_W    = 32,
    parameter int WORDS     = 256,
    parameter int ADDR_W    = 22,
    parameter int LATENCY   = 1,
    parameter int RDW_MODE  = 0,
    parameter     INIT_FILE = ""
) (
    input logic   clk,
    input logic   rst,
    ram_hs_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int DEPTH = LATENCY + 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(LATENCY + 2);

    // ------------------------------------------------------------------
    // storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [WORDS];

    // ------------------------------------------------------------------
    // request decode
    // ------------------------------------------------------------------
    logic              acc;        // request accepted this cycle
    logic              pop;        // response handed over this cycle
    logic              in_range;
    logic              is_write;
    logic              wr_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;    // current contents of the addressed word
    logic [DATA_W-1:0] merged;     // contents after applying the enabled lanes
    logic [DATA_W-1:0] s_data;     // response data produced at accept time
    logic              s_perr;     // parity error seen at accept time
    logic              s_err;
    logic [CW-1:0]     credits;

    assign in_range = (bus.req_addr < ADDR_W'(WORDS));
    assign is_write = (bus.req_we != '0);
    assign idx      = bus.req_addr[IDX_W-1:0];
    assign rd_word  = mem[idx];
    assign acc      = bus.req_valid && bus.req_ready;
    assign wr_en    = acc && in_range && is_write;

    // merge the enabled write lanes into the stored word (write-first view)
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.req_we[i]) begin
                merged[8*i +: 8] = bus.req_wdata[8*i +: 8];
            end
        end
    end

    // out-of-range responses always return zero data
    assign s_data = !in_range      ? '0 :
                    (RDW_MODE != 0) ? merged : rd_word;
    assign s_err  = !in_range || s_perr;

    // memory update on the accept edge; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_we[i]) begin
                    mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    // ------------------------------------------------------------------
    // per-lane even parity
    // ------------------------------------------------------------------
    logic [NB-1:0] par_mem [WORDS];
    logic [NB-1:0] rd_par;
    logic [NB-1:0] new_par;
    logic          par_bad;

    assign rd_par = par_mem[idx];

    // parity bit makes each stored lane plus its bit an even number of ones
    always_comb begin
        new_par = '0;
        for (int i = 0; i < NB; i++) begin
            new_par[i] = ^bus.req_wdata[8*i +: 8];
        end
    end

    // any lane whose data and parity bit disagree flags the read
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (^{rd_word[8*i +: 8], rd_par[i]}) begin
                par_bad = 1'b1;
            end
        end
    end

    // parity written together with each enabled lane
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_we[i]) begin
                    par_mem[idx][i] <= new_par[i];
                end
            end
        end
    end

    // only reads report parity; writes refresh the lanes they touch
    assign s_perr = par_bad && !is_write && in_range;
`else
    assign s_perr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // read pipeline: LATENCY-1 register stages ahead of the FIFO
    // ------------------------------------------------------------------
    logic              push_v;
    logic [DATA_W-1:0] push_d;
    logic              push_e;

    generate
        if (LATENCY == 1) begin : g_nopipe
            assign push_v = acc;
            assign push_d = s_data;
            assign push_e = s_err;
        end else begin : g_pipe
            logic [LATENCY-2:0] pv;
            logic [LATENCY-2:0] pe;
            logic [DATA_W-1:0]  pd [LATENCY-1];

            // shift accepted responses toward the FIFO, one stage per cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv <= '0;
                    pe <= '0;
                    for (int k = 0; k < LATENCY - 1; k++) begin
                        pd[k] <= '0;
                    end
                end else begin
                    pv[0] <= acc;
                    pe[0] <= s_err;
                    pd[0] <= s_data;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        pv[k] <= pv[k-1];
                        pe[k] <= pe[k-1];
                        pd[k] <= pd[k-1];
                    end
                end
            end

            assign push_v = pv[LATENCY-2];
            assign push_d = pd[LATENCY-2];
            assign push_e = pe[LATENCY-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // output FIFO, head drives the response channel
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] f_data [DEPTH];
    logic [DEPTH-1:0]  f_err;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     f_cnt;

    assign bus.rsp_valid = (f_cnt != '0);
    assign bus.rsp_rdata = f_data[rd_ptr];
    assign bus.rsp_err   = f_err[rd_ptr];
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    // FIFO storage and pointers; reset empties it and zeroes the head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            f_cnt  <= '0;
            f_err  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                f_data[k] <= '0;
            end
        end else begin
            if (push_v) begin
                f_data[wr_ptr] <= push_d;
                f_err[wr_ptr]  <= push_e;
                wr_ptr         <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push_v && !pop) begin
                f_cnt <= f_cnt + 1'b1;
            end else if (pop && !push_v) begin
                f_cnt <= f_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // credits: free slots across pipeline and FIFO
    // ------------------------------------------------------------------
    // accept consumes a slot, response handshake returns one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CW'(LATENCY + 1);
        end else if (acc && !pop) begin
            credits <= credits - 1'b1;
        end else if (pop && !acc) begin
            credits <= credits + 1'b1;
        end
    end

    assign bus.req_ready = !rst && (credits != '0);
endmodule

// File: tb/tb_ram_hs.sv
// tb_ram_hs: directed bench for ram_hs. Two instances share one stimulus bus:
// dut_a (LATENCY=1, read-first) and dut_b (LATENCY=2, write-first); sel picks
// which one sees req_valid/rsp_ready and whose outputs are observed.
`timescale 1ns/1ps
module tb_ram_hs;
    localparam int DW = 32;
    localparam int AW = 22;
    localparam int NB = DW / 8;
    localparam int EW = DW + 2;   // {check_data, err, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    ram_hs_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    ram_hs_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    ram_hs #(.DATA_W(DW), .WORDS(256), .ADDR_W(AW), .LATENCY(1), .RDW_MODE(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ram_hs #(.DATA_W(DW), .WORDS(256), .ADDR_W(AW), .LATENCY(2), .RDW_MODE(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // ---------------- shared stimulus ----------------
    logic          sel = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [NB-1:0] req_we = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b1;

    assign bus_a.req_valid = req_valid && !sel;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_we    = req_we;
    assign bus_a.req_wdata = req_wdata;
    assign bus_a.rsp_ready = rsp_ready && !sel;
    assign bus_b.req_valid = req_valid && sel;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_we    = req_we;
    assign bus_b.req_wdata = req_wdata;
    assign bus_b.rsp_ready = rsp_ready && sel;

    logic          cur_ready;
    logic          cur_rsp_valid;
    logic [DW-1:0] cur_rdata;
    logic          cur_err;
    assign cur_ready     = sel ? bus_b.req_ready : bus_a.req_ready;
    assign cur_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign cur_rdata     = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    assign cur_err       = sel ? bus_b.rsp_err   : bus_a.rsp_err;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;

    always @(negedge clk) begin
        #2;
        if (!rst && cur_rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err", 64'(cur_err), 64'(e[DW]));
                if (e[DW+1]) check("rsp_rdata", 64'(cur_rdata), 64'(e[DW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [AW-1:0] a, input logic [NB-1:0] we, input logic [DW-1:0] wd,
                        input logic chk, input logic err, input logic [DW-1:0] d);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        #1;
        while (!cur_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!cur_ready) begin
            check("send_ready", 64'(cur_ready), 64'd1);
            req_valid = 1'b0;
        end else begin
            exp_q.push_back({chk, err, d});
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int            n_acc;
    logic          acc_now;
    logic [AW-1:0] a_cur;

    initial begin
        // reset state
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rsp_valid", 64'(bus_a.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(bus_a.rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(bus_a.rsp_err),   64'd0);
        check("rst_req_ready", 64'(bus_a.req_ready), 64'd0);
        check("rst_credits_a", 64'(dut_a.credits),   64'd2);
        check("rst_credits_b", 64'(dut_b.credits),   64'd3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ready_after", 64'(bus_a.req_ready), 64'd1);

        // reset with a response in flight
        sel = 1'b0;
        send(22'd7, 4'hf, 32'hCAFE0007, 1'b0, 1'b0, 32'h0);
        drain();
        rsp_ready = 1'b0;
        send(22'd7, 4'h0, 32'h0, 1'b1, 1'b0, 32'hCAFE0007);
        check("t1_inflight", 64'(bus_a.rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t1_rst_valid", 64'(bus_a.rsp_valid), 64'd0);
        check("t1_rst_ready", 64'(bus_a.req_ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t1_ready_after", 64'(bus_a.req_ready), 64'd1);
        check("t1_credits",     64'(dut_a.credits),   64'd2);
        send(22'd7, 4'h0, 32'h0, 1'b1, 1'b0, 32'hCAFE0007);
        drain();

        // byte-lane write and LATENCY=2 read timing
        sel = 1'b1;
        send(22'd0, 4'hf, 32'hffffffff, 1'b1, 1'b0, 32'hffffffff);
        send(22'd0, 4'b0010, 32'h00000100, 1'b1, 1'b0, 32'hffff01ff);
        drain();
        send(22'd0, 4'h0, 32'h0, 1'b1, 1'b0, 32'hffff01ff);
        check("t2_lat_early", 64'(bus_b.rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("t2_lat_on", 64'(bus_b.rsp_valid), 64'd1);
        drain();

        // read-during-write data, read-first (a) and write-first (b)
        sel = 1'b0;
        send(22'd5, 4'hf, 32'h11111111, 1'b0, 1'b0, 32'h0);
        send(22'd5, 4'hf, 32'h22222222, 1'b1, 1'b0, 32'h11111111);
        send(22'd5, 4'h0, 32'h0,        1'b1, 1'b0, 32'h22222222);
        drain();
        sel = 1'b1;
        send(22'd5, 4'hf, 32'h11111111, 1'b1, 1'b0, 32'h11111111);
        send(22'd5, 4'hf, 32'h22222222, 1'b1, 1'b0, 32'h22222222);
        send(22'd5, 4'h0, 32'h0,        1'b1, 1'b0, 32'h22222222);
        drain();

        // backpressure: two credits on dut_a, then in-order release
        sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(AW'(k), 4'hf, 32'hA5A50000 + k, 1'b0, 1'b0, 32'h0);
        end
        drain();
        rsp_ready = 1'b0;
        n_acc = 0;
        a_cur = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 4'h0;
        req_addr  = a_cur;
        for (int i = 0; i < 6; i++) begin
            #1;
            acc_now = cur_ready;
            if (acc_now) begin
                exp_q.push_back({1'b1, 1'b0, 32'hA5A50000 + 32'(a_cur)});
                n_acc++;
            end
            @(negedge clk);
            if (acc_now) begin
                a_cur++;
                req_addr = a_cur;
            end
        end
        #1;
        check("t4_accepted", 64'(n_acc), 64'd2);
        check("t4_stalled",  64'(cur_ready), 64'd0);
        check("t4_credits",  64'(dut_a.credits), 64'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && a_cur < 4; i++) begin
            #1;
            acc_now = cur_ready;
            if (acc_now) exp_q.push_back({1'b1, 1'b0, 32'hA5A50000 + 32'(a_cur)});
            @(negedge clk);
            if (acc_now) begin
                a_cur++;
                req_addr = a_cur;
            end
        end
        req_valid = 1'b0;
        check("t4_issued", 64'(a_cur), 64'd4);
        drain();

        // out-of-range read and write; aliased word must stay intact
        send(22'd44,  4'hf, 32'h33445566, 1'b0, 1'b0, 32'h0);
        send(22'd256, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0);
        send(22'd300, 4'hf, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0);
        send(22'd44,  4'h0, 32'h0,        1'b1, 1'b0, 32'h33445566);
        drain();

        // parity: corrupt the stored lane-1 parity bit of word 3
        send(22'd3, 4'hf, 32'h90A0B0C0, 1'b0, 1'b0, 32'h0);
        drain();
`ifdef RAM_PARITY_EN
        dut_a.par_mem[3][1] = ~dut_a.par_mem[3][1];
        send(22'd3, 4'h0, 32'h0, 1'b1, 1'b1, 32'h90A0B0C0);
`else
        send(22'd3, 4'h0, 32'h0, 1'b1, 1'b0, 32'h90A0B0C0);
`endif
        drain();

        // full throughput on dut_b with rsp_ready held high
        sel = 1'b1;
        for (int k = 8; k < 12; k++) begin
            send(AW'(k), 4'hf, 32'h0B0B0000 + k, 1'b1, 1'b0, 32'h0B0B0000 + k);
        end
        drain();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 4'h0;
        for (int k = 8; k < 12; k++) begin
            req_addr = AW'(k);
            #1;
            check("tput_ready", 64'(cur_ready), 64'd1);
            exp_q.push_back({1'b1, 1'b0, 32'h0B0B0000 + k});
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
